// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst register access block:
// command opcodes and the transaction state encoding.
package spi_pkg;

    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    function automatic logic [7:0] frame_cmd(input logic is_read);
        return is_read ? CMD_READ : CMD_WRITE;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timebase: pulses tick on every CLK_DIV-th enabled ck cycle,
// restarting from zero whenever en drops.
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic ck,
    input  logic nRST,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge ck or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        tick = en && (cnt == LAST);
    end

endmodule

// File: rtl/spi_burst_rw.sv
// SPI mode-0 master issuing one command byte, one register address byte and
// a burst of 1..MAX_BYTES data bytes per transaction, read or write.
module spi_burst_rw
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned MAX_BYTES = 8,
    localparam int unsigned LEN_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic             ck,
    input  logic             nRST,
    input  logic             start,
    input  logic             rw,
    input  logic [7:0]       reg_name,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wdata,
    input  logic             miso,
    output logic             wnext,
    output logic [7:0]       data_out,
    output logic             rvalid,
    output logic             busy,
    output logic             ready,
    output logic             nCS,
    output logic             sclk,
    output logic             mosi
);

    localparam int unsigned BW = LEN_W + 1;

    spi_state_t state, state_nxt;

    logic             tick;
    logic             rw_q;
    logic [7:0]       reg_q;
    logic [7:0]       wbuf;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       tx_sr;
    logic [6:0]       rx_sr;
    logic [2:0]       bit_cnt;
    logic [BW-1:0]    byte_idx;
    logic             phase;

    logic             len_ok;
    logic             accept;
    logic [BW-1:0]    last_byte;
    logic [BW-1:0]    byte_idx_sat;
    logic             sample;
    logic             bit_end;
    logic             frame_end;
    logic [7:0]       next_byte;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .ck   (ck),
        .nRST (nRST),
        .en   (state != ST_IDLE),
        .tick (tick)
    );

    always_comb begin
        len_ok       = (len != '0) && (len <= LEN_W'(MAX_BYTES));
        accept       = (state == ST_IDLE) && start && len_ok;
        last_byte    = {1'b0, len_q} + BW'(1);
        // Byte index stops at the last data byte so a wrap can never reopen the frame.
        byte_idx_sat = (byte_idx == last_byte) ? byte_idx : byte_idx + BW'(1);
        sample       = (state == ST_SHIFT) && tick && !phase;
        bit_end      = (state == ST_SHIFT) && tick && phase && (bit_cnt == 3'd7);
        frame_end    = bit_end && (byte_idx == last_byte);
    end

    // Byte index 0 is the command, 1 the address, 2.. the data bytes.
    always_comb begin
        next_byte = 8'h00;
        if (byte_idx_sat == BW'(1)) begin
            next_byte = reg_q;
        end else if (!rw_q) begin
            next_byte = (byte_idx_sat == BW'(2)) ? wbuf : wdata;
        end
    end

    always_ff @(posedge ck or negedge nRST) begin
        if (!nRST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)    state_nxt = ST_SETUP;
            ST_SETUP: if (tick)      state_nxt = ST_SHIFT;
            ST_SHIFT: if (frame_end) state_nxt = ST_HOLD;
            ST_HOLD:  if (tick)      state_nxt = ST_GAP;
            ST_GAP:   if (tick)      state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        nCS   = !(state inside {ST_SETUP, ST_SHIFT, ST_HOLD});
        sclk  = (state == ST_SHIFT) && phase;
        mosi  = (state == ST_SHIFT) ? tx_sr[7] : 1'b0;
        busy  = (state != ST_IDLE) && !((state == ST_GAP) && tick);
        ready = (state == ST_GAP) && tick;
        // Write byte 0 is taken with the request; bytes 1.. as the previous byte ends.
        wnext = nRST && ((accept && !rw) ||
                         (bit_end && !frame_end && !rw_q && (byte_idx >= BW'(2))));
    end

    always_ff @(posedge ck or negedge nRST) begin
        if (!nRST) begin
            rw_q     <= 1'b0;
            reg_q    <= '0;
            wbuf     <= '0;
            len_q    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            phase    <= 1'b0;
            data_out <= '0;
            rvalid   <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            if (accept) begin
                rw_q     <= rw;
                reg_q    <= reg_name;
                len_q    <= len;
                wbuf     <= wdata;
                bit_cnt  <= '0;
                byte_idx <= '0;
                phase    <= 1'b0;
            end
            if ((state == ST_SETUP) && tick) begin
                tx_sr <= frame_cmd(rw_q);
            end
            if (sample) begin
                phase <= 1'b1;
                rx_sr <= {rx_sr[5:0], miso};
                if (rw_q && (byte_idx >= BW'(2)) && (bit_cnt == 3'd7)) begin
                    data_out <= {rx_sr, miso};
                    rvalid   <= 1'b1;
                end
            end
            if ((state == ST_SHIFT) && tick && phase) begin
                phase   <= 1'b0;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_idx <= byte_idx_sat;
                    tx_sr    <= next_byte;
                end else begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
            end
        end
    end

endmodule
